// File: rtl/core_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : core_result_collector_if
// Brief    : Valid/ready output stream carrying drained accumulator words.
// Revision : 1.0 - initial release
// ============================================================================
interface core_result_collector_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface
`default_nettype wire

// File: rtl/core_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : core_result_collector
// Brief    : Shifts accumulator results out of the daisy-chained core array,
//            buffers them in a first-word-fall-through FIFO and streams them
//            out with a last marker on the final word of each drain.
// Revision : 1.0 - initial release
// ============================================================================
module core_result_collector #(
    parameter int CORE_NUM   = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic                   update,
    output logic                   out_period,
    input  wire logic [DATA_W-1:0] acc_in,
    core_result_collector_if.master m_axis
);
    localparam int c_BEAT_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(CORE_NUM - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_done;

    // Each entry holds {last, data}
    logic [DATA_W:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_last_beat;
    logic w_head_last;

    assign w_full      = (r_count == c_FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = out_period;
    assign w_pop       = m_axis.m_tvalid & m_axis.m_tready;
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_head_last = r_mem[r_rd_ptr][DATA_W];

    assign m_axis.m_tvalid = !w_empty;
    assign m_axis.m_tdata  = r_mem[r_rd_ptr][DATA_W-1:0];
    assign m_axis.m_tlast  = !w_empty && w_head_last;
    assign done            = r_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the drain ends when the word tagged last leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nxt = c_S_SHIFT;
            c_S_SHIFT: if (w_push && w_last_beat) w_state_nxt = c_S_FLUSH;
            c_S_FLUSH: if (w_pop && w_head_last) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Core controls: shift only while the buffer has room, so a stall holds acc_right
    always_comb begin
        busy       = (r_state != c_S_IDLE);
        out_period = (r_state == c_S_SHIFT) && !w_full;
        update     = out_period && (r_beat == '0);
    end

    // Beat counter, cleared between drains and after the final beat
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_S_IDLE)) begin
            r_beat <= '0;
        end else if (out_period) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    // done pulses in the first IDLE cycle after the last word is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_S_FLUSH) && (w_state_nxt == c_S_IDLE);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; a beat captures the head core's acc with its last tag
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_beat, acc_in};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_core_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_result_collector
// Brief    : Self-checking bench with a behavioural core-chain model and a
//            word-order reference built from the loaded acc_left values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_result_collector;
    localparam int CN = 8;
    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          update;
    logic          out_period;
    logic [DW-1:0] acc_in;

    core_result_collector_if #(.DATA_W(DW)) m_if ();

    core_result_collector #(
        .CORE_NUM  (CN),
        .DATA_W    (DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .update    (update),
        .out_period(out_period),
        .acc_in    (acc_in),
        .m_axis    (m_if)
    );

    always #5 clk = ~clk;

    // Behavioural core chain: update presents acc_left, shift moves acc_right toward the head
    logic [DW-1:0] acc_left  [CN];
    logic [DW-1:0] acc_right [CN];

    always @(posedge clk) begin
        if (out_period) begin
            for (int i = 0; i < CN - 1; i++)
                acc_right[i] <= update ? acc_left[i+1] : acc_right[i+1];
            acc_right[CN-1] <= '0;
        end
    end

    assign acc_in = update ? acc_left[0] : acc_right[0];

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    logic [DW-1:0] exp_d [$];
    int            done_seen;

    // Log this cycle's handshake and done, then move to the next mid-cycle point
    task automatic tick();
        if (m_if.m_tvalid && m_if.m_tready) begin
            got_d.push_back(m_if.m_tdata);
            got_l.push_back(m_if.m_tlast);
        end
        if (done) done_seen++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        done_seen = 0;
    endtask

    task automatic load_cores(input bit ramp);
        for (int i = 0; i < CN; i++) begin
            acc_left[i] = ramp ? DW'((i + 1) * 10) : DW'($urandom);
            exp_d.push_back(acc_left[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_if.m_tready = 1'b0;
        tick(); tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (update !== 1'b0) begin miscompares++; $display("FAIL reset_update got=%b exp=0", update); end
        vectors++; if (out_period !== 1'b0) begin miscompares++; $display("FAIL reset_out_period got=%b exp=0", out_period); end
        vectors++; if (m_if.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b exp=0", m_if.m_tvalid); end
        vectors++; if (m_if.m_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got=%b exp=0", m_if.m_tlast); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_drain_basic();
        logic e;
        clear_log();
        load_cores(1'b1);
        m_if.m_tready = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            start = (k == 0);
            e = (k == 1);
            vectors++; if (update !== e) begin miscompares++; $display("FAIL basic_update cyc=%0d got=%b exp=%b", k, update, e); end
            e = (k >= 1 && k <= CN);
            vectors++; if (out_period !== e) begin miscompares++; $display("FAIL basic_out_period cyc=%0d got=%b exp=%b", k, out_period, e); end
            e = (k >= 1 && k <= CN + 1);
            vectors++; if (busy !== e) begin miscompares++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", k, busy, e); end
            e = (k == CN + 2);
            vectors++; if (done !== e) begin miscompares++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", k, done, e); end
            e = (k >= 2 && k <= CN + 1);
            vectors++; if (m_if.m_tvalid !== e) begin miscompares++; $display("FAIL basic_tvalid cyc=%0d got=%b exp=%b", k, m_if.m_tvalid, e); end
            e = (k == CN + 1);
            vectors++; if (m_if.m_tlast !== e) begin miscompares++; $display("FAIL basic_tlast cyc=%0d got=%b exp=%b", k, m_if.m_tlast, e); end
            if (k >= 2 && k <= CN + 1) begin
                vectors++; if (m_if.m_tdata !== exp_d[k-2]) begin miscompares++; $display("FAIL basic_tdata cyc=%0d got=%0d exp=%0d", k, m_if.m_tdata, exp_d[k-2]); end
            end
            tick();
        end
        start = 1'b0;
        vectors++; if (got_d.size() !== CN) begin miscompares++; $display("FAIL basic_count got=%0d exp=%0d", got_d.size(), CN); end
    endtask

    task automatic test_backpressure();
        int nlast;
        clear_log();
        load_cores(1'b0);
        for (int k = 0; k < 200 && done_seen == 0; k++) begin
            start = (k == 0);
            m_if.m_tready = (k >= 20);
            if (k >= 1 && k <= 19) begin
                vectors++; if (out_period !== (k <= FD)) begin miscompares++; $display("FAIL bp_out_period cyc=%0d got=%b exp=%b", k, out_period, (k <= FD)); end
            end
            if (k == 19) begin
                vectors++; if (m_if.m_tdata !== exp_d[0] || m_if.m_tvalid !== 1'b1 || m_if.m_tlast !== 1'b0) begin
                    miscompares++; $display("FAIL bp_hold got=%0d/%b/%b exp=%0d/1/0", m_if.m_tdata, m_if.m_tvalid, m_if.m_tlast, exp_d[0]);
                end
            end
            tick();
        end
        start = 1'b0;
        vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL bp_done got=%0d exp=1", done_seen); end
        vectors++; if (got_d.size() !== CN) begin miscompares++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), CN); end
        nlast = 0;
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            vectors++; if (got_d[i] !== exp_d[i]) begin miscompares++; $display("FAIL bp_word idx=%0d got=%0d exp=%0d", i, got_d[i], exp_d[i]); end
            if (got_l[i]) nlast++;
        end
        vectors++; if (nlast !== 1 || got_l[got_l.size()-1] !== 1'b1) begin miscompares++; $display("FAIL bp_tlast got=%0d exp=1", nlast); end
    endtask

    task automatic test_back_to_back();
        int drains;
        clear_log();
        drains = 0;
        for (int k = 0; k < 3000 && done_seen < 5; k++) begin
            m_if.m_tready = 1'($urandom_range(0, 1));
            if (k == 0 || (done && drains < 5)) begin
                start = 1'b1;
                load_cores(1'b0);
                drains++;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        m_if.m_tready = 1'b1;
        tick(); tick();
        vectors++; if (done_seen !== 5) begin miscompares++; $display("FAIL b2b_done got=%0d exp=5", done_seen); end
        vectors++; if (got_d.size() !== 5 * CN) begin miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), 5 * CN); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            vectors++; if (got_d[i] !== exp_d[i]) begin miscompares++; $display("FAIL b2b_word idx=%0d got=%0d exp=%0d", i, got_d[i], exp_d[i]); end
            vectors++; if (got_l[i] !== ((i % CN) == CN - 1)) begin miscompares++; $display("FAIL b2b_tlast idx=%0d got=%b exp=%b", i, got_l[i], ((i % CN) == CN - 1)); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_start_ignored();
        int  beats;
        bit  sent;
        clear_log();
        load_cores(1'b0);
        beats = 0;
        sent  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            m_if.m_tready = (k >= 6);
            start = (k == 0) || (k == 3);
            if (beats == CN && busy && !sent) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            if (out_period) beats++;
            tick();
        end
        start = 1'b0;
        vectors++; if (beats !== CN) begin miscompares++; $display("FAIL ign_beats got=%0d exp=%0d", beats, CN); end
        vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL ign_done got=%0d exp=1", done_seen); end
        vectors++; if (got_d.size() !== CN) begin miscompares++; $display("FAIL ign_count got=%0d exp=%0d", got_d.size(), CN); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            vectors++; if (got_d[i] !== exp_d[i]) begin miscompares++; $display("FAIL ign_word idx=%0d got=%0d exp=%0d", i, got_d[i], exp_d[i]); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        load_cores(1'b0);
        for (int k = 0; k <= 4; k++) begin
            start = (k == 0);
            m_if.m_tready = (k == 2);
            rst = (k == 4);
            if (k == 4) begin
                vectors++; if (got_d.size() !== 1 || m_if.m_tvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre popped=%0d tvalid=%b exp=1/1", got_d.size(), m_if.m_tvalid); end
            end
            tick();
        end
        start = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        vectors++; if (m_if.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tvalid got=%b exp=0", m_if.m_tvalid); end
        vectors++; if (update !== 1'b0) begin miscompares++; $display("FAIL rstmid_update got=%b exp=0", update); end
        vectors++; if (out_period !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_period got=%b exp=0", out_period); end
        rst = 1'b0;
        tick();
        clear_log();
        load_cores(1'b0);
        m_if.m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            start = (k == 0);
            tick();
        end
        start = 1'b0;
        vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL rstmid_done got=%0d exp=1", done_seen); end
        vectors++; if (got_d.size() !== CN) begin miscompares++; $display("FAIL rstmid_count got=%0d exp=%0d", got_d.size(), CN); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            vectors++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == CN - 1)) begin
                miscompares++; $display("FAIL rstmid_word idx=%0d got=%0d/%b exp=%0d/%b", i, got_d[i], got_l[i], exp_d[i], (i == CN - 1));
            end
        end
    endtask

    task automatic test_simul_push_pop();
        clear_log();
        load_cores(1'b0);
        for (int k = 0; k < 40; k++) begin
            start = (k == 0);
            m_if.m_tready = (k >= 4);
            if (k >= 4 && k <= CN) begin
                vectors++; if (out_period !== 1'b1) begin miscompares++; $display("FAIL pp_out_period cyc=%0d got=%b exp=1", k, out_period); end
            end
            tick();
        end
        start = 1'b0;
        vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL pp_done got=%0d exp=1", done_seen); end
        vectors++; if (got_d.size() !== CN) begin miscompares++; $display("FAIL pp_count got=%0d exp=%0d", got_d.size(), CN); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            vectors++; if (got_d[i] !== exp_d[i]) begin miscompares++; $display("FAIL pp_word idx=%0d got=%0d exp=%0d", i, got_d[i], exp_d[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        m_if.m_tready = 1'b0;
        for (int i = 0; i < CN; i++) begin
            acc_left[i]  = '0;
            acc_right[i] = '0;
        end
        done_seen = 0;
        @(negedge clk);
        test_reset();
        test_drain_basic();
        test_backpressure();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_simul_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_result_collector.md
Name: core_result_collector

Overview:
- Drains accumulator results out of the daisy-chained core array after a computation and streams them to the DMA side.
- Generates the `update` and `out_period` controls shared by all cores.
- Samples the head core's `acc` output on every shift beat and buffers the samples in a small FIFO.
- Presents the words on a valid/ready output stream with a `last` marker on the final word of each drain.

Parameters:
- CORE_NUM, 8: number of cores in the chain; words per drain.
- DATA_W, 32: accumulator word width.
- FIFO_DEPTH, 16: output buffer depth in words; power of 2, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse requesting a drain; ignored while busy.
- busy  output  1  high while a drain is in progress.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- update  output  1  to all cores; selects acc_left onto acc and loads the chain.
- out_period  output  1  to all cores; shift-enable for acc_right.
- acc_in  input  DATA_W  acc output of the head core of the chain.
- m_tdata  output  DATA_W  stream data.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- m_tlast  output  1  marks word CORE_NUM of a drain.

Behaviour:
- Reset is synchronous and active-high, and may be applied in any state.
  - State returns to IDLE, the FIFO is emptied and the beat counter clears.
  - busy, done, update, out_period, m_tvalid and m_tlast are all 0 in the cycle after rst.
- States: IDLE, SHIFT, FLUSH.
  - IDLE -> SHIFT on start=1.
  - SHIFT -> FLUSH after CORE_NUM shift beats have been issued.
  - FLUSH -> IDLE on the handshake (m_tvalid & m_tready) of the word tagged last.
- busy = (state != IDLE).
- done is registered: it pulses in the first IDLE cycle after FLUSH.
  - A start arriving in the same cycle as done is accepted.
- Shift beats:
  - In SHIFT, out_period = !fifo_full, where fifo_full comes from the registered count.
  - Each cycle with out_period=1 is one beat. In that cycle acc_in is pushed into the FIFO together with last = (beat == CORE_NUM-1), and the beat counter increments.
  - update = out_period & (beat == 0), so update is high exactly once per drain, on the first beat. acc_in then equals the head core's acc_left, and every core's acc_right loads from its neighbour.
  - Beats 1..CORE_NUM-1 have update=0; acc_in equals the head core's acc_right.
  - When the FIFO is full, out_period stays 0. The cores then hold acc_right, so the stall is lossless. Beats may be non-contiguous.
- FIFO:
  - First-word-fall-through: m_tvalid = !empty; m_tdata and m_tlast come from the head entry.
  - Pop on m_tvalid & m_tready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No push occurs when full. Pop when empty is impossible because m_tvalid=0.
- Output rules:
  - m_tdata stays stable while m_tvalid=1 and m_tready=0.
  - The word order on m_tdata is exactly the beat order.
- Latency, with start at cycle 0 and an empty FIFO:
  - SHIFT from cycle 1; update=out_period=1 in cycle 1.
  - First m_tvalid in cycle 2.
  - With m_tready held at 1: words in cycles 2..CORE_NUM+1, m_tlast in cycle CORE_NUM+1, done in cycle CORE_NUM+2.
- start arriving during SHIFT or FLUSH is dropped; no queueing.
- No arithmetic is performed on data: acc_in passes through bit-exact at DATA_W.

Test Plan:
- Drain with m_tready=1: model 8 cores with acc_left = 10,20,...,80 and pulse start -> update high only in cycle 1; out_period high in cycles 1..8; m_tdata = 10,20,...,80 in cycles 2..9; m_tlast in cycle 9 only; done in cycle 10; busy high in cycles 1..9.
- Backpressure with FIFO_DEPTH=4 and m_tready=0 until cycle 20: out_period drops after 4 beats and cores hold their state; after ready rises, all 8 words arrive in order with no loss or duplication and a single tlast.
- Random m_tready toggling (50%) across 5 back-to-back drains, with start issued in the done cycle -> 40 words in order, tlast on words 8,16,...,40, exactly 5 done pulses.
- start pulsed during SHIFT and again during FLUSH -> ignored; the word count stays 8 and only one done pulse occurs.
- rst asserted after beat 3 while 2 words are still buffered -> the next cycle shows busy=0, m_tvalid=0, update=0, out_period=0; a subsequent start produces a full clean 8-word drain.
- Simultaneous push and pop at count = FIFO_DEPTH-1 with m_tready=1 -> count is unchanged and out_period stays asserted (never reaches full).
